// File: rtl/tf_feeder.sv
// Twiddle-factor feeder: sweeps the twiddle BRAM and pushes each word REPEAT times.
// Define TF_FEEDER_CONJ_EN to push conj(W) by flipping the imaginary sign bit.
module tf_feeder #(
  parameter int FLOAT_LEN   = 32,
  parameter int TF_NUM      = 8,
  parameter int TF_ADDR_LEN = 3,
  parameter int REPEAT      = 4,
  parameter int RD_LAT      = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   tf_rd_en,
  output logic [TF_ADDR_LEN-1:0] tf_addr,
  input  logic [2*FLOAT_LEN-1:0] tf_data,
  output logic [2*FLOAT_LEN-1:0] fifo_din,
  output logic                   fifo_wr_en,
  input  logic                   fifo_full
);

  localparam int DW    = 2*FLOAT_LEN;
  localparam int IDX_W = TF_ADDR_LEN + 1;
  localparam int REP_W = (REPEAT > 1) ? $clog2(REPEAT) : 1;
  localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TF_NUM - 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT - 1);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(RD_LAT - 1);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    PUSH,
    DONE
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_nxt;
  logic [REP_W-1:0] rep;
  logic [LAT_W-1:0] wcnt;
  logic [DW-1:0]    cap;

`ifdef TF_FEEDER_CONJ_EN
  localparam logic [DW-1:0] CONJ_MASK = DW'(1) << (FLOAT_LEN - 1);
  assign cap = tf_data ^ CONJ_MASK;
`else
  assign cap = tf_data;
`endif

  // Gated by full combinationally so a write never lands on a full FIFO.
  assign fifo_wr_en = (state == PUSH) & ~fifo_full;
  assign idx_nxt    = idx + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      tf_rd_en <= 1'b0;
      tf_addr  <= '0;
      fifo_din <= '0;
      idx      <= '0;
      rep      <= '0;
      wcnt     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state    <= READ;
            busy     <= 1'b1;
            tf_rd_en <= 1'b1;
            tf_addr  <= '0;
            idx      <= '0;
            rep      <= '0;
          end
        end
        READ: begin
          tf_rd_en <= 1'b0;
          wcnt     <= LAT_LOAD;
          state    <= WAIT;
        end
        WAIT: begin
          if (wcnt == '0) begin
            fifo_din <= cap;
            state    <= PUSH;
          end else begin
            wcnt <= wcnt - 1'b1;
          end
        end
        PUSH: begin
          if (fifo_wr_en) begin
            if (rep == REP_LAST) begin
              rep <= '0;
              if (idx == IDX_LAST) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                idx      <= idx_nxt;
                tf_addr  <= idx_nxt[TF_ADDR_LEN-1:0];
                tf_rd_en <= 1'b1;
                state    <= READ;
              end
            end else begin
              rep <= rep + 1'b1;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tf_feeder.sv
// Bench for tf_feeder: RD_LAT=1 and RD_LAT=3 instances against BRAM models.
// Expected FIFO words are queued at start and compared after each frame.
module tb_tf_feeder;

  localparam int FL = 32;
  localparam int W  = 2*FL;
  localparam int N  = 8;
  localparam int AL = 3;
  localparam int RP = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  logic fifo_full = 1'b0;

  logic          busy_a, done_a, rd_a, wr_a;
  logic [AL-1:0] addr_a;
  logic [W-1:0]  tfd_a, din_a;
  logic          busy_b, done_b, rd_b, wr_b;
  logic [AL-1:0] addr_b;
  logic [W-1:0]  tfd_b, din_b;

  always #5 clk = ~clk;

  tf_feeder #(.FLOAT_LEN(FL), .TF_NUM(N), .TF_ADDR_LEN(AL),
              .REPEAT(RP), .RD_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a),
    .done(done_a), .tf_rd_en(rd_a), .tf_addr(addr_a),
    .tf_data(tfd_a), .fifo_din(din_a), .fifo_wr_en(wr_a),
    .fifo_full(fifo_full));

  tf_feeder #(.FLOAT_LEN(FL), .TF_NUM(N), .TF_ADDR_LEN(AL),
              .REPEAT(RP), .RD_LAT(3)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b),
    .done(done_b), .tf_rd_en(rd_b), .tf_addr(addr_b),
    .tf_data(tfd_b), .fifo_din(din_b), .fifo_wr_en(wr_b),
    .fifo_full(1'b0));

  logic [W-1:0]  mem [N];
  logic [W-1:0]  garb = '0;
  logic          va = 1'b0;
  logic [AL-1:0] aa = '0;
  logic [2:0]    vb = '0;
  logic [AL-1:0] ab0 = '0, ab1 = '0, ab2 = '0;

  always @(posedge clk) begin
    garb <= {$urandom, $urandom};
    va   <= rd_a;
    aa   <= addr_a;
    vb   <= {vb[1:0], rd_b};
    ab0  <= addr_b;
    ab1  <= ab0;
    ab2  <= ab1;
  end
  assign tfd_a = va ? mem[aa] : garb;
  assign tfd_b = vb[2] ? mem[ab2] : garb;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [W-1:0]  exp_a[$], obs_a[$], exp_b[$], obs_b[$];
  logic [AL-1:0] radr_a[$];
  int rcyc_a[$], wcyc_a[$], dcyc_a[$];
  int rcyc_b[$], wcyc_b[$], dcyc_b[$];
  int full_viol = 0;

  always @(negedge clk) begin
    if (wr_a) begin obs_a.push_back(din_a); wcyc_a.push_back(cyc); end
    if (rd_a) begin radr_a.push_back(addr_a); rcyc_a.push_back(cyc); end
    if (done_a) dcyc_a.push_back(cyc);
    if (wr_a && fifo_full) full_viol <= full_viol + 1;
    if (wr_b) begin obs_b.push_back(din_b); wcyc_b.push_back(cyc); end
    if (rd_b) rcyc_b.push_back(cyc);
    if (done_b) dcyc_b.push_back(cyc);
  end

  int pass_cnt = 0;
  int tot_cnt = 0;

  function automatic logic [W-1:0] exp_word(input logic [W-1:0] d);
`ifdef TF_FEEDER_CONJ_EN
    return d ^ (64'h1 << (FL-1));
`else
    return d;
`endif
  endfunction

  task automatic clear_mon();
    exp_a.delete(); obs_a.delete(); radr_a.delete();
    rcyc_a.delete(); wcyc_a.delete(); dcyc_a.delete();
    exp_b.delete(); obs_b.delete();
    rcyc_b.delete(); wcyc_b.delete(); dcyc_b.delete();
  endtask

  task automatic load_mem(input bit rnd);
    for (int k = 0; k < N; k++)
      mem[k] = rnd ? {$urandom, $urandom} : {32'(k), ~32'(k)};
  endtask

  task automatic queue_exp(input bit to_b);
    for (int k = 0; k < N; k++)
      for (int r = 0; r < RP; r++)
        if (to_b) exp_b.push_back(exp_word(mem[k]));
        else exp_a.push_back(exp_word(mem[k]));
  endtask

  task automatic pulse(input bit to_b);
    @(negedge clk);
    if (to_b) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_done(input bit to_b, input int budget, output bit ok);
    int n = 0;
    while (((to_b ? dcyc_b.size() : dcyc_a.size()) == 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    ok = (to_b ? dcyc_b.size() : dcyc_a.size()) != 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tot_cnt += 7;
    if (busy_a !== 1'b0) $display("FAIL rst_busy got %b want 0", busy_a); else pass_cnt++;
    if (done_a !== 1'b0) $display("FAIL rst_done got %b want 0", done_a); else pass_cnt++;
    if (rd_a !== 1'b0) $display("FAIL rst_rd_en got %b want 0", rd_a); else pass_cnt++;
    if (wr_a !== 1'b0) $display("FAIL rst_wr_en got %b want 0", wr_a); else pass_cnt++;
    if (addr_a !== '0) $display("FAIL rst_addr got %0d want 0", addr_a); else pass_cnt++;
    if (din_a !== '0) $display("FAIL rst_din got %h want 0", din_a); else pass_cnt++;
    if (busy_b !== 1'b0) $display("FAIL rst_busy_b got %b want 0", busy_b); else pass_cnt++;
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    bit ok;
    logic [W-1:0] e, o;
    int i;
    clear_mon();
    load_mem(1'b0);
    queue_exp(1'b0);
    pulse(1'b0);
    wait_done(1'b0, 300, ok);
    tot_cnt++;
    if (!ok) $display("FAIL basic_timeout got no done want done"); else pass_cnt++;
    tot_cnt++;
    if (obs_a.size() !== N*RP) $display("FAIL basic_wr_count got %0d want %0d", obs_a.size(), N*RP); else pass_cnt++;
    tot_cnt++;
    if (rcyc_a.size() !== N) $display("FAIL basic_rd_count got %0d want %0d", rcyc_a.size(), N); else pass_cnt++;
    tot_cnt++;
    if (dcyc_a.size() !== 1) $display("FAIL basic_done_count got %0d want 1", dcyc_a.size()); else pass_cnt++;
    if (ok && rcyc_a.size() > 0 && wcyc_a.size() > 0) begin
      tot_cnt += 3;
      if (wcyc_a[0] - rcyc_a[0] !== 2) $display("FAIL basic_first_wr_lat got %0d want 2", wcyc_a[0] - rcyc_a[0]); else pass_cnt++;
      if (dcyc_a[0] - rcyc_a[0] !== 48) $display("FAIL basic_frame_len got %0d want 48", dcyc_a[0] - rcyc_a[0]); else pass_cnt++;
      if (dcyc_a[0] - wcyc_a[wcyc_a.size()-1] !== 1) $display("FAIL basic_done_gap got %0d want 1", dcyc_a[0] - wcyc_a[wcyc_a.size()-1]); else pass_cnt++;
    end
    for (int k = 0; k < radr_a.size(); k++) begin
      tot_cnt++;
      if (radr_a[k] !== AL'(k)) $display("FAIL basic_addr[%0d] got %0d want %0d", k, radr_a[k], k); else pass_cnt++;
    end
    tot_cnt++;
    if (busy_a !== 1'b0) $display("FAIL basic_busy_after got %b want 0", busy_a); else pass_cnt++;
    i = 0;
    while (obs_a.size() > 0 && exp_a.size() > 0) begin
      e = exp_a.pop_front();
      o = obs_a.pop_front();
      tot_cnt++;
      if (o !== e) $display("FAIL basic_word[%0d] got %h want %h", i, o, e); else pass_cnt++;
      i++;
    end
  endtask

  task automatic test_stall();
    bit ok;
    logic [W-1:0] e, o;
    int n;
    clear_mon();
    load_mem(1'b1);
    queue_exp(1'b0);
    pulse(1'b0);
    n = 0;
    while (obs_a.size() < 13 && n < 200) begin @(posedge clk); n++; end
    tot_cnt++;
    if (obs_a.size() < 13) $display("FAIL stall_reach got %0d want 13", obs_a.size()); else pass_cnt++;
    #1 fifo_full = 1'b1;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      tot_cnt += 2;
      if (wr_a !== 1'b0) $display("FAIL stall_wr[%0d] got %b want 0", s, wr_a); else pass_cnt++;
      if (din_a !== exp_word(mem[3])) $display("FAIL stall_din[%0d] got %h want %h", s, din_a, exp_word(mem[3])); else pass_cnt++;
    end
    @(posedge clk);
    #1 fifo_full = 1'b0;
    wait_done(1'b0, 300, ok);
    tot_cnt++;
    if (!ok) $display("FAIL stall_timeout got no done want done"); else pass_cnt++;
    tot_cnt++;
    if (obs_a.size() !== N*RP) $display("FAIL stall_wr_count got %0d want %0d", obs_a.size(), N*RP); else pass_cnt++;
    if (ok && rcyc_a.size() > 0) begin
      tot_cnt++;
      if (dcyc_a[0] - rcyc_a[0] !== 53) $display("FAIL stall_frame_len got %0d want 53", dcyc_a[0] - rcyc_a[0]); else pass_cnt++;
    end
    n = 0;
    while (obs_a.size() > 0 && exp_a.size() > 0) begin
      e = exp_a.pop_front();
      o = obs_a.pop_front();
      tot_cnt++;
      if (o !== e) $display("FAIL stall_word[%0d] got %h want %h", n, o, e); else pass_cnt++;
      n++;
    end
    tot_cnt++;
    if (full_viol !== 0) $display("FAIL stall_wr_while_full got %0d want 0", full_viol); else pass_cnt++;
  endtask

  task automatic test_latency();
    bit ok;
    logic [W-1:0] e, o;
    int n;
    clear_mon();
    load_mem(1'b1);
    queue_exp(1'b1);
    pulse(1'b1);
    wait_done(1'b1, 400, ok);
    tot_cnt++;
    if (!ok) $display("FAIL lat_timeout got no done want done"); else pass_cnt++;
    tot_cnt++;
    if (obs_b.size() !== N*RP) $display("FAIL lat_wr_count got %0d want %0d", obs_b.size(), N*RP); else pass_cnt++;
    tot_cnt++;
    if (rcyc_b.size() !== N) $display("FAIL lat_rd_count got %0d want %0d", rcyc_b.size(), N); else pass_cnt++;
    if (ok && rcyc_b.size() == N && wcyc_b.size() == N*RP) begin
      for (int k = 0; k < N; k++) begin
        tot_cnt++;
        if (wcyc_b[k*RP] - rcyc_b[k] !== 4) $display("FAIL lat_first_wr[%0d] got %0d want 4", k, wcyc_b[k*RP] - rcyc_b[k]); else pass_cnt++;
      end
      tot_cnt++;
      if (dcyc_b[0] - rcyc_b[0] !== 64) $display("FAIL lat_frame_len got %0d want 64", dcyc_b[0] - rcyc_b[0]); else pass_cnt++;
    end
    n = 0;
    while (obs_b.size() > 0 && exp_b.size() > 0) begin
      e = exp_b.pop_front();
      o = obs_b.pop_front();
      tot_cnt++;
      if (o !== e) $display("FAIL lat_word[%0d] got %h want %h", n, o, e); else pass_cnt++;
      n++;
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [W-1:0] e, o;
    int n;
    clear_mon();
    load_mem(1'b1);
    pulse(1'b0);
    n = 0;
    while (obs_a.size() < 21 && n < 200) begin @(posedge clk); n++; end
    tot_cnt++;
    if (obs_a.size() < 21) $display("FAIL rmid_reach got %0d want 21", obs_a.size()); else pass_cnt++;
    #2 rst = 1'b0;
    #1;
    tot_cnt += 4;
    if (wr_a !== 1'b0) $display("FAIL rmid_wr got %b want 0", wr_a); else pass_cnt++;
    if (busy_a !== 1'b0) $display("FAIL rmid_busy got %b want 0", busy_a); else pass_cnt++;
    if (din_a !== '0) $display("FAIL rmid_din got %h want 0", din_a); else pass_cnt++;
    if (addr_a !== '0) $display("FAIL rmid_addr got %0d want 0", addr_a); else pass_cnt++;
    repeat (3) @(negedge clk);
    clear_mon();
    rst = 1'b1;
    repeat (6) @(negedge clk);
    tot_cnt += 3;
    if (obs_a.size() !== 0) $display("FAIL rmid_idle_wr got %0d want 0", obs_a.size()); else pass_cnt++;
    if (rcyc_a.size() !== 0) $display("FAIL rmid_idle_rd got %0d want 0", rcyc_a.size()); else pass_cnt++;
    if (busy_a !== 1'b0) $display("FAIL rmid_idle_busy got %b want 0", busy_a); else pass_cnt++;
    queue_exp(1'b0);
    pulse(1'b0);
    wait_done(1'b0, 300, ok);
    tot_cnt++;
    if (obs_a.size() !== N*RP) $display("FAIL rmid_fresh_count got %0d want %0d", obs_a.size(), N*RP); else pass_cnt++;
    n = 0;
    while (obs_a.size() > 0 && exp_a.size() > 0) begin
      e = exp_a.pop_front();
      o = obs_a.pop_front();
      tot_cnt++;
      if (o !== e) $display("FAIL rmid_word[%0d] got %h want %h", n, o, e); else pass_cnt++;
      n++;
    end
  endtask

  task automatic test_start_ignored();
    bit ok;
    clear_mon();
    load_mem(1'b0);
    pulse(1'b0);
    repeat (10) @(negedge clk);
    pulse(1'b0);
    repeat (15) @(negedge clk);
    pulse(1'b0);
    wait_done(1'b0, 300, ok);
    repeat (10) @(negedge clk);
    tot_cnt += 4;
    if (obs_a.size() !== N*RP) $display("FAIL ign_wr_count got %0d want %0d", obs_a.size(), N*RP); else pass_cnt++;
    if (dcyc_a.size() !== 1) $display("FAIL ign_done_count got %0d want 1", dcyc_a.size()); else pass_cnt++;
    if (rcyc_a.size() !== N) $display("FAIL ign_rd_count got %0d want %0d", rcyc_a.size(), N); else pass_cnt++;
    if (busy_a !== 1'b0) $display("FAIL ign_busy got %b want 0", busy_a); else pass_cnt++;
  endtask

  task automatic test_conj();
    bit ok;
    logic [W-1:0] want;
    clear_mon();
    load_mem(1'b0);
    mem[0] = 64'h3F800000_3F000000;
`ifdef TF_FEEDER_CONJ_EN
    want = 64'h3F800000_BF000000;
`else
    want = 64'h3F800000_3F000000;
`endif
    pulse(1'b0);
    wait_done(1'b0, 300, ok);
    tot_cnt++;
    if (obs_a.size() == 0) $display("FAIL conj_word got none want %h", want);
    else if (obs_a[0] !== want) $display("FAIL conj_word got %h want %h", obs_a[0], want);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_latency();
    test_reset_mid();
    test_start_ignored();
    test_conj();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
